adc_channel_averager: RTL
=========================

ADC_CHANNEL_AVERAGER -- requirements
Module: adc_channel_averager

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, number of averaged channels (1..16); channel indices 0..NUM_CH-1.
REQ-002 SHALL have parameter DATA_W, default 12, sample width (8..16).
REQ-003 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per result (0..4).
REQ-004 SHALL have port clk_clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports st_valid in 1, st_channel in 5, st_data in DATA_W: ADC response stream; no backpressure.
REQ-007 SHALL have ports s0_address in 5, s0_read in 1, s0_write in 1, s0_writedata in 16: Avalon-MM slave command.
REQ-008 SHALL have ports s0_readdata out 16, s0_readdatavalid out 1, s0_waitrequest out 1: Avalon-MM slave response.
REQ-009 SHALL have port irq  out  1  level interrupt.

Function
REQ-010 Address map: 0..NUM_CH-1 = RESULT[n] (RO); 16 = CTRL (RW); 17 = STATUS (RO, read-clear); 18 = OVERRUN (RO); other addresses read 0, writes ignored.
REQ-011 CTRL: bit0 EN, bit1 CLR (write-1 self-clearing, reads 0), bit2 IRQ_EN; other bits read 0.
REQ-012 s0_waitrequest SHALL be constant 0; every read accepted in one cycle.
REQ-013 Read latency fixed 1: s0_readdatavalid high exactly the cycle after s0_read; s0_readdata valid that cycle, 0 otherwise.
REQ-014 s0_read and s0_write together: write SHALL take effect, read returns pre-write value.
REQ-015 Sample accepted when st_valid=1, EN=1, st_channel<NUM_CH; else ignored with no state change.
REQ-016 Per channel: accumulator DATA_W+AVG_LOG2 bits, sample counter AVG_LOG2 bits.
REQ-017 Accepted sample with counter < 2^AVG_LOG2-1: acc += st_data, counter += 1.
REQ-018 Accepted sample with counter = 2^AVG_LOG2-1: RESULT[ch] <= (acc+st_data)>>AVG_LOG2 (truncating), acc <= 0, counter <= 0, STATUS[ch] <= 1; RESULT visible on bus next cycle.
REQ-019 AVG_LOG2=0: every accepted sample SHALL write RESULT directly (pass-through, latency 1).
REQ-020 RESULT zero-extended to 16 bits on readdata.
REQ-021 Result completing while STATUS[ch] already 1 SHALL increment OVERRUN (16-bit, saturates at 0xFFFF); RESULT still overwritten.
REQ-022 STATUS read returns flags in bits NUM_CH-1:0 and clears every flag returned; flag set in the same cycle as clearing read SHALL remain 1.
REQ-023 CLR SHALL zero all accumulators, counters, RESULT, STATUS, OVERRUN in one cycle; a sample arriving that cycle is discarded; EN/IRQ_EN unchanged.
REQ-024 Clearing EN SHALL hold accumulators/counters (partial averages resume on re-enable).
REQ-025 irq SHALL be registered: IRQ_EN & (STATUS != 0), updated one cycle after STATUS changes.

Reset
REQ-026 On reset_reset_n=0, immediately: CTRL=0, accumulators, counters, RESULT, STATUS, OVERRUN=0; s0_readdata=0, s0_readdatavalid=0, irq=0.
REQ-027 Reset asserted mid-average SHALL discard partial sums; first result after release needs full 2^AVG_LOG2 samples.
REQ-028 Reset release synchronous to clk_clk; first access permitted the cycle after release.

Verification
REQ-029 Defaults, EN=1, ch3 samples 100,101,102,103 -> RESULT[3]=101 one cycle after 4th sample, STATUS=0x0008, irq 0 (IRQ_EN=0).
REQ-030 IRQ_EN=1, ch0 eight samples 0xFFF without STATUS read -> RESULT[0]=0xFFF, OVERRUN=1, irq=1; STATUS read returns 0x0001, irq 0 one cycle later.
REQ-031 st_channel=9 (NUM_CH=8) and EN=0 samples -> no state change; STATUS=0, OVERRUN=0.
REQ-032 Two ch5 samples, CLR written coincident with a third sample, then four samples 8,8,8,8 -> RESULT[5]=8.
REQ-033 STATUS read in same cycle ch2 completes -> read returns prior flags, STATUS[2]=1 afterwards.
REQ-034 Reset pulse after two ch1 samples, then 4 samples of 20 -> RESULT[1]=20; all registers read 0 immediately after reset.

Source files
------------

// File: rtl/adc_channel_averager_if.sv
// Bundle of the ADC response stream and the Avalon-MM slave port for the channel averager.
// The master side drives the stream and bus commands; the slave side returns read data.
interface adc_channel_averager_if #(
   parameter int DATA_W = 12
);
   logic              st_valid;
   logic [4:0]        st_channel;
   logic [DATA_W-1:0] st_data;
   logic [4:0]        s0_address;
   logic              s0_read;
   logic              s0_write;
   logic [15:0]       s0_writedata;
   logic [15:0]       s0_readdata;
   logic              s0_readdatavalid;
   logic              s0_waitrequest;

   modport master (
      output st_valid, st_channel, st_data,
      output s0_address, s0_read, s0_write, s0_writedata,
      input  s0_readdata, s0_readdatavalid, s0_waitrequest
   );

   modport slave (
      input  st_valid, st_channel, st_data,
      input  s0_address, s0_read, s0_write, s0_writedata,
      output s0_readdata, s0_readdatavalid, s0_waitrequest
   );
endinterface

// File: rtl/adc_channel_averager.sv
// Per-channel block averager for an ADC sample stream with an Avalon-MM register window.
// Each channel sums 2^AVG_LOG2 samples, publishes the truncated mean and flags completion.
module adc_channel_averager #(
   parameter int NUM_CH   = 8,
   parameter int DATA_W   = 12,
   parameter int AVG_LOG2 = 2
) (
   input  logic                    clk_clk,
   input  logic                    reset_reset_n,
   adc_channel_averager_if.slave   av,
   output logic                    irq
);
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [4:0] A_CTRL = 5'd16;
   localparam logic [4:0] A_STAT = 5'd17;
   localparam logic [4:0] A_OVR  = 5'd18;

   function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
      avg_trunc = DATA_W'(sum >> AVG_LOG2);
   endfunction

   logic              r_en;
   logic              r_irq_en;
   logic [ACC_W-1:0]  r_acc    [NUM_CH];
   logic [CNT_W-1:0]  r_cnt    [NUM_CH];
   logic [DATA_W-1:0] r_result [NUM_CH];
   logic [NUM_CH-1:0] r_status;
   logic [15:0]       r_overrun;
   logic [15:0]       r_rdata_p1;
   logic              r_vld_p1;
   logic              r_irq;

   logic              w_ctrl_wr;
   logic              w_clr;
   logic              w_stat_rd;
   logic              w_take;
   logic              w_done;
   logic              w_ovr_hit;
   logic [ACC_W-1:0]  w_sum;
   logic [NUM_CH-1:0] w_set;
   logic [15:0]       w_rdata;

   always_comb begin
      w_ctrl_wr = av.s0_write && (av.s0_address == A_CTRL);
      w_clr     = w_ctrl_wr && av.s0_writedata[1];
      w_stat_rd = av.s0_read && (av.s0_address == A_STAT);
      // A clear in progress swallows any sample arriving in the same cycle
      w_take    = av.st_valid && r_en && ({27'd0, av.st_channel} < 32'(NUM_CH)) && !w_clr;
      w_sum     = '0;
      w_done    = 1'b0;
      w_set     = '0;
      w_ovr_hit = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_take && (av.st_channel == 5'(c))) begin
            w_sum  = r_acc[c] + ACC_W'(av.st_data);
            w_done = (r_cnt[c] == CNT_LAST);
            if (w_done) begin
               w_set[c]  = 1'b1;
               w_ovr_hit = r_status[c];
            end
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      case (av.s0_address)
         A_CTRL:  w_rdata = {13'd0, r_irq_en, 1'b0, r_en};
         A_STAT:  w_rdata = 16'(r_status);
         A_OVR:   w_rdata = r_overrun;
         default: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (av.s0_address == 5'(c)) w_rdata = 16'(r_result[c]);
            end
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_en       <= 1'b0;
         r_irq_en   <= 1'b0;
         r_status   <= '0;
         r_overrun  <= '0;
         r_rdata_p1 <= '0;
         r_vld_p1   <= 1'b0;
         r_irq      <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_acc[c]    <= '0;
            r_cnt[c]    <= '0;
            r_result[c] <= '0;
         end
      end else begin
         if (w_ctrl_wr) begin
            r_en     <= av.s0_writedata[0];
            r_irq_en <= av.s0_writedata[2];
         end
         // Read response stage: data is captured before any same-cycle write lands
         r_vld_p1   <= av.s0_read;
         r_rdata_p1 <= av.s0_read ? w_rdata : 16'd0;
         r_irq      <= r_irq_en && (|r_status);
         if (w_clr) begin
            r_status  <= '0;
            r_overrun <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
               r_acc[c]    <= '0;
               r_cnt[c]    <= '0;
               r_result[c] <= '0;
            end
         end else begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (w_take && (av.st_channel == 5'(c))) begin
                  if (w_done) begin
                     r_acc[c]    <= '0;
                     r_cnt[c]    <= '0;
                     r_result[c] <= avg_trunc(w_sum);
                  end else begin
                     r_acc[c] <= w_sum;
                     r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                  end
               end
            end
            // Flags set this cycle survive a concurrent read-clear
            r_status <= w_stat_rd ? w_set : (r_status | w_set);
            if (w_ovr_hit && (r_overrun != 16'hFFFF)) r_overrun <= r_overrun + 16'd1;
         end
      end
   end

   assign av.s0_readdata      = r_rdata_p1;
   assign av.s0_readdatavalid = r_vld_p1;
   assign av.s0_waitrequest   = 1'b0;
   assign irq                 = r_irq;
endmodule
